// File: rtl/itrx_aib_phy_apbm.sv
// APB initiator for the AIB PHY register slave.
// Takes single read/write commands on a valid/ready port, runs one APB
// SETUP/ACCESS transfer at a time with an optional wait-state timeout, and
// reports completion with a one-cycle response pulse.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | cmd_ready high, waiting for a command
//   ST_SETUP  | psel high, penable low, exactly one cycle
//   ST_ACCESS | psel and penable high, waiting for pready or timeout
module itrx_aib_phy_apbm #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [11:0] paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);
  localparam logic [TMO_W-1:0] CNT_SAT = '1;
  localparam bit               TMO_EN  = (TMO_MAX != 0);

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             tmo_hit;

  // Timeout fires only when enabled and the slave has used up its wait budget.
  assign tmo_hit = TMO_EN && (wait_cnt == TMO_LIM);

  // Transfer sequencer; all outputs are registered here.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            penable   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            // pready wins over a timeout landing in the same cycle
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            cmd_ready <= 1'b1;
            if (!pwrite) begin
              rsp_rdata <= prdata;
            end
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (wait_cnt != CNT_SAT) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_itrx_aib_phy_apbm.sv
// Bench for itrx_aib_phy_apbm: scoreboarded random traffic against a
// slave model with programmable wait states, plus reset-abort and
// timeout-disabled scenarios on a second instance.
module tb_itrx_aib_phy_apbm;

  localparam int TMO = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] paddr;
  logic        pwrite, psel, penable, pready = 1'b0;
  logic [31:0] pwdata, prdata = '0;

  logic        d0_valid = 1'b0, d0_write = 1'b0;
  logic [11:0] d0_addr = '0;
  logic [31:0] d0_wdata = '0;
  logic        d0_ready, d0_rsp_valid, d0_rsp_err;
  logic [31:0] d0_rsp_rdata;
  logic [11:0] d0_paddr;
  logic        d0_pwrite, d0_psel, d0_penable, d0_pready = 1'b0;
  logic [31:0] d0_pwdata, d0_prdata = '0;

  itrx_aib_phy_apbm #(.TMO_W(8), .TMO_MAX(TMO)) u_dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  itrx_aib_phy_apbm #(.TMO_W(8), .TMO_MAX(0)) u_dut0 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(d0_valid), .cmd_ready(d0_ready), .cmd_write(d0_write),
    .cmd_addr(d0_addr), .cmd_wdata(d0_wdata),
    .rsp_valid(d0_rsp_valid), .rsp_err(d0_rsp_err), .rsp_rdata(d0_rsp_rdata),
    .paddr(d0_paddr), .pwrite(d0_pwrite), .psel(d0_psel), .penable(d0_penable),
    .pwdata(d0_pwdata), .prdata(d0_prdata), .pready(d0_pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          w;
    int          gap;
    bit          b2b;
  } cmd_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          rsp_edge;
    logic [11:0] addr;
    bit          wr;
    logic [31:0] wdata;
  } exp_t;

  cmd_t        cq[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_w = 0;
  int          acc = 0;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  // Slave model: asserts pready after cur_w wait states in ACCESS.
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready = (acc == cur_w);
      acc++;
    end else begin
      pready = 1'b0;
      acc = 0;
    end
  end

  // Monitor: checks APB address phase and pops expected responses.
  always @(negedge pclk) begin
    if (presetn) begin
      if (penable) chk("penable_needs_psel", {31'd0, psel}, 32'd1);
      if (psel && penable && sb.size() > 0) begin
        chk("paddr_stable", {20'd0, paddr}, {20'd0, sb[0].addr});
        chk("pwrite_stable", {31'd0, pwrite}, {31'd0, sb[0].wr});
        if (sb[0].wr) chk("pwdata_stable", pwdata, sb[0].wdata);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_latency_edge", cyc, e.rsp_edge);
          chk("cmd_ready_at_rsp", {31'd0, cmd_ready}, 32'd1);
          chk("psel_low_at_rsp", {31'd0, psel}, 32'd0);
        end
      end
    end
  end

  task automatic run_cmds();
    int budget = 0;
    int last_acc = 0;
    while (cq.size() > 0 && budget < 5000) begin
      cmd_t c;
      exp_t e;
      int m;
      c = cq.pop_front();
      repeat (c.gap) @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = c.wr;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      while (!cmd_ready && budget < 5000) begin
        @(negedge pclk);
        budget++;
      end
      if (!cmd_ready) break;
      cur_w  = c.w;
      prdata = c.rdata;
      m = (c.w < TMO) ? c.w : TMO;
      if (c.w > TMO) begin
        e.err = 1'b1;
        model_rdata = '0;
      end else begin
        e.err = 1'b0;
        if (!c.wr) model_rdata = c.rdata;
      end
      e.rdata    = model_rdata;
      e.rsp_edge = cyc + 1 + 2 + m;
      e.addr     = c.addr;
      e.wr       = c.wr;
      e.wdata    = c.wdata;
      sb.push_back(e);
      if (c.b2b) chk("b2b_spacing", cyc + 1 - last_acc, 3);
      last_acc = cyc + 1;
      @(negedge pclk);
      budget++;
      cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    while (sb.size() > 0 && budget < 5000) begin
      @(negedge pclk);
      budget++;
    end
    if (cq.size() > 0 || sb.size() > 0) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic cmd_t mk(bit wr, logic [11:0] a, logic [31:0] wd, logic [31:0] rd,
                              int w, int gap, bit b2b);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = wd; c.rdata = rd; c.w = w; c.gap = gap; c.b2b = b2b;
    return c;
  endfunction

  initial begin
    int bad;
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_paddr", {20'd0, paddr}, 32'd0);
    chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    cq.push_back(mk(1'b1, 12'h004, 32'hA5A5_0001, 32'h0, 0, 0, 1'b0));
    cq.push_back(mk(1'b0, 12'h010, 32'h0, 32'h1234_5678, 3, 2, 1'b0));
    cq.push_back(mk(1'b0, 12'h018, 32'h0, 32'h0BAD_CAFE, TMO, 1, 1'b0));
    cq.push_back(mk(1'b0, 12'h01C, 32'h0, 32'h5555_AAAA, 50, 1, 1'b0));
    cq.push_back(mk(1'b1, 12'h100, 32'h1111_1111, 32'h0, 0, 2, 1'b0));
    cq.push_back(mk(1'b0, 12'h104, 32'h0, 32'h2222_2222, 0, 0, 1'b1));
    cq.push_back(mk(1'b1, 12'h108, 32'h3333_3333, 32'h0, 0, 0, 1'b1));
    for (int i = 0; i < 40; i++) begin
      cq.push_back(mk(1'($urandom_range(0, 1)), 12'($urandom), $urandom, $urandom,
                      $urandom_range(0, 7), $urandom_range(0, 2), 1'b0));
    end
    run_cmds();

    // Reset mid-ACCESS: no response may appear for the aborted transfer.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020; cmd_wdata = 32'hDEAD_BEEF;
    cur_w = 100;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_psel", {31'd0, psel}, 32'd1);
    chk("pre_rst_penable", {31'd0, penable}, 32'd1);
    #2;
    presetn = 1'b0;
    #1;
    chk("async_rst_psel", {31'd0, psel}, 32'd0);
    chk("async_rst_penable", {31'd0, penable}, 32'd0);
    chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge pclk);
    presetn = 1'b1;
    model_rdata = '0;
    cq.push_back(mk(1'b1, 12'h044, 32'h0F0F_0F0F, 32'h0, 1, 1, 1'b0));
    cq.push_back(mk(1'b0, 12'h048, 32'h0, 32'h7777_8888, 2, 0, 1'b0));
    run_cmds();

    // Timeout disabled: 1000 wait states must not abort.
    @(negedge pclk);
    d0_valid = 1'b1; d0_write = 1'b0; d0_addr = 12'h030;
    d0_prdata = 32'hCAFE_F00D;
    @(negedge pclk);
    d0_valid = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge pclk);
      if (d0_rsp_valid) bad++;
    end
    chk("tmo0_no_abort", bad, 0);
    chk("tmo0_still_access", {30'd0, d0_psel, d0_penable}, 32'd3);
    d0_pready = 1'b1;
    @(negedge pclk);
    d0_pready = 1'b0;
    chk("tmo0_rsp_valid", {31'd0, d0_rsp_valid}, 32'd1);
    chk("tmo0_rsp_err", {31'd0, d0_rsp_err}, 32'd0);
    chk("tmo0_rsp_rdata", d0_rsp_rdata, 32'hCAFE_F00D);
    @(negedge pclk);
    chk("tmo0_rsp_pulse", {31'd0, d0_rsp_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
